// File: rtl/fetch_if.sv
// Fetch-unit bus bundle: instruction memory port, redirect input and decoder handshake.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misaligned_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc, misaligned_err,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc, misaligned_err,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, DEPTH-entry instruction FIFO, redirect flush.
// Define FETCH_ALIGN_CHECK_EN to enable the misaligned-redirect error pulse.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  fetch_if.master bus
);
  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [31:0]   req_pc_reg, req_pc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic          issue, push, pop, buf_valid;
  logic [31:0]   redirect_target;

  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;
  assign buf_valid       = (count_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_FETCH;
      pc_reg     <= RESET_PC;
      req_pc_reg <= RESET_PC;
      count_reg  <= '0;
      head_reg   <= '0;
      tail_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      req_pc_reg <= req_pc_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      tail_reg   <= tail_next;
    end
  end

  // Issue only from FETCH, so the in-flight slot is always reserved in the buffer.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    req_pc_next = req_pc_reg;
    issue       = 1'b0;
    push        = 1'b0;
    case (state_reg)
      ST_FETCH: begin
        if (!bus.redirect_valid && (count_reg < DEPTH_C)) begin
          issue       = 1'b1;
          req_pc_next = pc_reg;
          pc_next     = pc_reg + 32'd4;
          state_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.redirect_valid) begin
          state_next = bus.imem_rvalid ? ST_FETCH : ST_DROP;
        end else if (bus.imem_rvalid) begin
          push       = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_DROP: begin
        // The response of the abandoned request ends the drop even if redirected again.
        if (bus.imem_rvalid) state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
    if (bus.redirect_valid) pc_next = redirect_target;
  end

  assign pop = buf_valid & bus.instr_ready & ~bus.redirect_valid;

  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (bus.redirect_valid) begin
      count_next = '0;
      head_next  = '0;
      tail_next  = '0;
    end else begin
      if (push) tail_next = tail_reg + 1'b1;
      if (pop)  head_next = head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[tail_reg] <= bus.imem_rdata;
      buf_pc[tail_reg]    <= req_pc_reg;
    end
  end

  assign bus.imem_req    = issue & rst_n;
  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = buf_valid;
  assign bus.instr       = buf_valid ? buf_instr[head_reg] : 32'h0;
  assign bus.instr_pc    = buf_valid ? buf_pc[head_reg]    : 32'h0;

`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.misaligned_err = rst_n & bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
`else
  assign bus.misaligned_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural instruction memory plus an expected-instruction queue.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_if bus();
  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q [$];
  logic [31:0] exp_pc;
  logic        exp_err;
  bit          mem_pending;
  int          mem_wait;
  int          mem_delay;
  logic [31:0] mem_addr;
  logic        obs_req, obs_valid, obs_err, obs_pop, obs_rv;
  logic [31:0] obs_addr, obs_instr, obs_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0033;
      32'h0000_0004: return 32'h4000_0033;
      32'h0000_0100: return 32'h0000_0013;
      default:       return a ^ 32'h5A5A_0013;
    endcase
  endfunction

  // One clock cycle: drive memory response, sample outputs, update memory/scoreboard, advance.
  task automatic tick();
    if (mem_pending) mem_wait--;
    if (mem_pending && mem_wait == 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(mem_addr);
      mem_pending     = 1'b0;
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
    #1;
    obs_rv    = bus.imem_rvalid;
    obs_req   = bus.imem_req;
    obs_addr  = bus.imem_addr;
    obs_valid = bus.instr_valid;
    obs_instr = bus.instr;
    obs_pc    = bus.instr_pc;
    obs_err   = bus.misaligned_err;
    obs_pop   = obs_valid & bus.instr_ready & ~bus.redirect_valid;
    if (obs_req) begin
      mem_pending = 1'b1;
      mem_wait    = mem_delay;
      mem_addr    = obs_addr;
      $display("req  addr=%h", obs_addr);
    end
    if (bus.redirect_valid) begin
      exp_q.delete();
      exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      $display("redirect pc=%h", bus.redirect_pc);
    end else if (obs_req) begin
      exp_q.push_back({exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
    end
    if (obs_pop) $display("pop  pc=%h instr=%h", obs_pc, obs_instr);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    exp_q.delete();
    exp_pc      = 32'h0;
    mem_pending = 1'b0;
    mem_delay   = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    mem_delay = 1;
    @(posedge clk);
    #1;
    v = {29'h0, bus.imem_req, bus.instr_valid, bus.misaligned_err};
    n_checks++; if (v !== 32'h0) $display("FAIL rst_strobes: got %b want 000", v[2:0]); else n_pass++;
    n_checks++; if (bus.imem_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", bus.imem_addr); else n_pass++;
    n_checks++; if (bus.instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", bus.instr); else n_pass++;
    n_checks++; if (bus.instr_pc !== 32'h0) $display("FAIL rst_instr_pc: got %h want 0", bus.instr_pc); else n_pass++;
    exp_q.delete();
    exp_pc = 32'h0;
    mem_pending = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++; if (obs_req !== 1'b1) $display("FAIL rst_first_req: got %b want 1", obs_req); else n_pass++;
    n_checks++; if (obs_addr !== 32'h0) $display("FAIL rst_first_addr: got %h want 0", obs_addr); else n_pass++;
  endtask

  // Continues straight from test_reset with the first request outstanding.
  task automatic test_sequential();
    logic [63:0] e;
    logic [31:0] want_addr = 32'h4;
    logic prev_req = 1'b1, prev_rv = 1'b0;
    int pops = 0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_req) begin
        n_checks++; if (prev_req) $display("FAIL seq_spacing: back-to-back req at %h", obs_addr); else n_pass++;
        n_checks++; if (obs_addr !== want_addr) $display("FAIL seq_addr: got %h want %h", obs_addr, want_addr); else n_pass++;
        want_addr = want_addr + 32'd4;
      end
      if (prev_rv) begin
        n_checks++; if (obs_valid !== 1'b1) $display("FAIL seq_latency: instr_valid %b want 1", obs_valid); else n_pass++;
      end
      if (obs_pop) begin
        pops++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        n_checks++; if ({obs_pc, obs_instr} !== e) $display("FAIL seq_pop: got %h/%h want %h/%h", obs_pc, obs_instr, e[63:32], e[31:0]); else n_pass++;
      end
      prev_req = obs_req;
      prev_rv  = obs_rv;
    end
    n_checks++; if (pops < 4) $display("FAIL seq_pop_count: got %0d want >=4", pops); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    int reqs = 0, pops = 0;
    apply_reset();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (obs_req) reqs++;
    end
    n_checks++; if (reqs != 2) $display("FAIL bp_req_count: got %0d want 2", reqs); else n_pass++;
    n_checks++; if (obs_req !== 1'b0) $display("FAIL bp_req_stall: got %b want 0", obs_req); else n_pass++;
    n_checks++; if (obs_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", obs_valid); else n_pass++;
    bus.instr_ready = 1'b1;
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_req) reqs++;
      if (obs_pop) begin
        pops++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        n_checks++; if ({obs_pc, obs_instr} !== e) $display("FAIL bp_pop: got %h/%h want %h/%h", obs_pc, obs_instr, e[63:32], e[31:0]); else n_pass++;
      end
    end
    n_checks++; if (pops < 2) $display("FAIL bp_drain: got %0d pops want >=2", pops); else n_pass++;
    n_checks++; if (reqs < 1) $display("FAIL bp_resume: got %0d reqs want >=1", reqs); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    logic [63:0] e;
    apply_reset();
    bus.instr_ready = 1'b1;
    mem_delay = 3;
    tick();
    mem_delay = 1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (obs_req !== 1'b0) $display("FAIL rw_req_on_redirect: got %b want 0", obs_req); else n_pass++;
    for (int i = 2; i <= 6; i++) begin
      tick();
      if (i <= 5) begin
        n_checks++; if (obs_valid !== 1'b0) $display("FAIL rw_valid_c%0d: got %b want 0", i, obs_valid); else n_pass++;
      end
      if (i == 4) begin
        n_checks++; if ({obs_req, obs_addr} !== {1'b1, 32'h100}) $display("FAIL rw_next_addr: got req=%b addr=%h want 1/00000100", obs_req, obs_addr); else n_pass++;
      end else if (i != 6) begin
        n_checks++; if (obs_req !== 1'b0) $display("FAIL rw_idle_c%0d: got %b want 0", i, obs_req); else n_pass++;
      end
      if (obs_pop) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        n_checks++; if ({obs_pc, obs_instr} !== e) $display("FAIL rw_pop: got %h/%h want %h/%h", obs_pc, obs_instr, e[63:32], e[31:0]); else n_pass++;
      end
    end
    n_checks++; if (obs_instr !== 32'h13) $display("FAIL rw_target_word: got %h want 00000013", obs_instr); else n_pass++;
  endtask

  task automatic test_redirect_full();
    logic [63:0] e;
    apply_reset();
    bus.instr_ready = 1'b0;
    tick();
    tick();
    tick();
    n_checks++; if ({obs_valid, obs_req} !== 2'b11) $display("FAIL rf_setup: got valid/req=%b want 11", {obs_valid, obs_req}); else n_pass++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    bus.instr_ready    = 1'b1;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (obs_rv !== 1'b1) $display("FAIL rf_coincide: rvalid %b want 1", obs_rv); else n_pass++;
    tick();
    n_checks++; if ({obs_valid, obs_instr} !== 33'h0) $display("FAIL rf_flushed: got valid=%b instr=%h want 0", obs_valid, obs_instr); else n_pass++;
    n_checks++; if ({obs_req, obs_addr} !== {1'b1, 32'h200}) $display("FAIL rf_target: got req=%b addr=%h want 1/00000200", obs_req, obs_addr); else n_pass++;
    tick();
    n_checks++; if (obs_valid !== 1'b0) $display("FAIL rf_stale: got %b want 0", obs_valid); else n_pass++;
    tick();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    n_checks++; if (!obs_pop || {obs_pc, obs_instr} !== e) $display("FAIL rf_pop: got %b %h/%h want 1 %h/%h", obs_pop, obs_pc, obs_instr, e[63:32], e[31:0]); else n_pass++;
  endtask

  task automatic test_misaligned();
    logic [63:0] e;
    apply_reset();
    bus.instr_ready = 1'b1;
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    tick();
    bus.redirect_valid = 1'b0;
    n_checks++; if (obs_req !== 1'b0) $display("FAIL ma_suppress: got %b want 0", obs_req); else n_pass++;
    n_checks++; if (obs_err !== exp_err) $display("FAIL ma_err_pulse: got %b want %b", obs_err, exp_err); else n_pass++;
    tick();
    n_checks++; if ({obs_req, obs_addr} !== {1'b1, 32'h100}) $display("FAIL ma_aligned_addr: got req=%b addr=%h want 1/00000100", obs_req, obs_addr); else n_pass++;
    n_checks++; if ({obs_err, obs_valid} !== 2'b00) $display("FAIL ma_after: got err/valid=%b want 00", {obs_err, obs_valid}); else n_pass++;
    tick();
    tick();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    n_checks++; if (!obs_pop || {obs_pc, obs_instr} !== e) $display("FAIL ma_pop: got %b %h/%h want 1 %h/%h", obs_pop, obs_pc, obs_instr, e[63:32], e[31:0]); else n_pass++;
  endtask

  task automatic test_wrap_and_reset();
    logic [63:0] e;
    logic [4:0]  v;
    apply_reset();
    bus.instr_ready = 1'b1;
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    n_checks++; if ({obs_req, obs_addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wr_top: got req=%b addr=%h want 1/fffffffc", obs_req, obs_addr); else n_pass++;
    tick();
    bus.instr_ready = 1'b0;
    mem_delay = 2;
    tick();
    n_checks++; if ({obs_req, obs_addr} !== {1'b1, 32'h0}) $display("FAIL wr_wrap: got req=%b addr=%h want 1/00000000", obs_req, obs_addr); else n_pass++;
    tick();
    rst_n = 1'b0;
    #1;
    v = {bus.imem_req, bus.instr_valid, bus.misaligned_err, 2'b00};
    n_checks++; if (v !== 5'b0) $display("FAIL wr_rst_strobes: got %b want 000", v[4:2]); else n_pass++;
    n_checks++; if (bus.imem_addr !== 32'h0) $display("FAIL wr_rst_addr: got %h want 0", bus.imem_addr); else n_pass++;
    n_checks++; if ({bus.instr, bus.instr_pc} !== 64'h0) $display("FAIL wr_rst_instr: got %h/%h want 0/0", bus.instr_pc, bus.instr); else n_pass++;
    exp_q.delete();
    exp_pc = 32'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    mem_delay = 1;
    tick();
    n_checks++; if ({obs_rv, obs_req, obs_addr} !== {2'b11, 32'h0}) $display("FAIL wr_restart: got rv=%b req=%b addr=%h want 1/1/00000000", obs_rv, obs_req, obs_addr); else n_pass++;
    tick();
    n_checks++; if (obs_valid !== 1'b0) $display("FAIL wr_stale_ignored: got %b want 0", obs_valid); else n_pass++;
    tick();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    n_checks++; if (!obs_pop || {obs_pc, obs_instr} !== e) $display("FAIL wr_pop: got %b %h/%h want 1 %h/%h", obs_pop, obs_pc, obs_instr, e[63:32], e[31:0]); else n_pass++;
  endtask

  initial begin
`ifdef FETCH_ALIGN_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_full();
    test_misaligned();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
